// File: rtl/audio_tone_sequencer.sv
// ============================================================================
// Module   : audio_tone_sequencer
// Purpose  : Note-table tone sequencer feeding one channel's period and mute.
//            Optional build macro AUDSEQ_LOOP_EN adds a `loop` input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_tone_sequencer #(
    parameter int ADDR_W      = 6,
    parameter int DUR_W       = 8,
    parameter int TICK_CYCLES = 25000
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [16+DUR_W-1:0]   wr_data,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     start_addr,
    input  logic                  stop,
`ifdef AUDSEQ_LOOP_EN
    input  logic                  loop,
`endif
    output logic [15:0]           period,
    output logic                  mute,
    output logic                  busy,
    output logic                  done
);

    localparam int c_DEPTH  = 1 << ADDR_W;
    localparam int c_TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DECODE = 2'd2,
        S_PLAY   = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_W-1:0]     r_addr, w_addr_nxt;
    logic [c_TICK_W-1:0]   r_tick, w_tick_nxt;
    logic [DUR_W-1:0]      r_dcnt, w_dcnt_nxt;
    logic [DUR_W-1:0]      r_dur, w_dur_nxt;
    logic [15:0]           r_period, w_period_nxt;
    logic                  r_mute, w_mute_nxt;
    logic                  r_done, w_done_nxt;

    logic [16+DUR_W-1:0]   r_mem [c_DEPTH];
    logic [16+DUR_W-1:0]   r_rd_data;
    logic [15:0]           w_ent_period;
    logic [DUR_W-1:0]      w_ent_dur;
    logic [DUR_W-1:0]      w_dcnt_inc;
    logic                  w_loop;
    logic [ADDR_W-1:0]     w_loop_addr;

    // Read-first RAM: a same-address write lands after the read samples old data
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        r_rd_data <= r_mem[r_addr];
    end

    assign w_ent_period = r_rd_data[16+DUR_W-1:DUR_W];
    assign w_ent_dur    = r_rd_data[DUR_W-1:0];
    assign w_dcnt_inc   = r_dcnt + 1'b1;

`ifdef AUDSEQ_LOOP_EN
    logic [ADDR_W-1:0] r_start_addr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_start_addr <= '0;
        end else if (start && !stop) begin
            r_start_addr <= start_addr;
        end
    end

    assign w_loop      = loop;
    assign w_loop_addr = r_start_addr;
`else
    assign w_loop      = 1'b0;
    assign w_loop_addr = '0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_tick_nxt   = r_tick;
        w_dcnt_nxt   = r_dcnt;
        w_dur_nxt    = r_dur;
        w_period_nxt = r_period;
        w_mute_nxt   = r_mute;
        w_done_nxt   = 1'b0;

        // stop beats a simultaneous start; in IDLE it is a no-op
        if (stop && (r_state != S_IDLE)) begin
            w_state_nxt  = S_IDLE;
            w_period_nxt = 16'h0000;
            w_mute_nxt   = 1'b1;
            w_done_nxt   = 1'b1;
        end else if (start && !stop) begin
            w_state_nxt = S_FETCH;
            w_addr_nxt  = start_addr;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_period_nxt = 16'h0000;
                    w_mute_nxt   = 1'b1;
                end
                S_FETCH: begin
                    w_state_nxt = S_DECODE;
                end
                S_DECODE: begin
                    if (w_ent_dur == '0) begin
                        if (w_loop) begin
                            w_addr_nxt  = w_loop_addr;
                            w_state_nxt = S_FETCH;
                        end else begin
                            w_state_nxt  = S_IDLE;
                            w_period_nxt = 16'h0000;
                            w_mute_nxt   = 1'b1;
                            w_done_nxt   = 1'b1;
                        end
                    end else begin
                        w_period_nxt = w_ent_period;
                        w_mute_nxt   = (w_ent_period == 16'h0000);
                        w_dur_nxt    = w_ent_dur;
                        w_tick_nxt   = '0;
                        w_dcnt_nxt   = '0;
                        w_addr_nxt   = r_addr + 1'b1;
                        w_state_nxt  = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (r_tick == c_TICK_LAST) begin
                        w_tick_nxt = '0;
                        w_dcnt_nxt = w_dcnt_inc;
                        if (w_dcnt_inc == r_dur) begin
                            w_state_nxt = S_FETCH;
                        end
                    end else begin
                        w_tick_nxt = r_tick + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_tick   <= '0;
            r_dcnt   <= '0;
            r_dur    <= '0;
            r_period <= 16'h0000;
            r_mute   <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_addr   <= w_addr_nxt;
            r_tick   <= w_tick_nxt;
            r_dcnt   <= w_dcnt_nxt;
            r_dur    <= w_dur_nxt;
            r_period <= w_period_nxt;
            r_mute   <= w_mute_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign period = r_period;
    assign mute   = r_mute;
    assign done   = r_done;
    assign busy   = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_audio_tone_sequencer.sv
// ============================================================================
// Module   : tb_audio_tone_sequencer
// Purpose  : Scoreboard bench; expected output segments (value + length) are
//            queued by stimulus and checked by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_audio_tone_sequencer;

    localparam int ADDR_W      = 6;
    localparam int DUR_W       = 8;
    localparam int TICK_CYCLES = 4;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic                wr_en = 1'b0;
    logic [ADDR_W-1:0]   wr_addr = '0;
    logic [16+DUR_W-1:0] wr_data = '0;
    logic                start = 1'b0;
    logic [ADDR_W-1:0]   start_addr = '0;
    logic                stop = 1'b0;
    logic                loop = 1'b0;
    logic [15:0]         period;
    logic                mute;
    logic                busy;
    logic                done;

    audio_tone_sequencer #(
        .ADDR_W      (ADDR_W),
        .DUR_W       (DUR_W),
        .TICK_CYCLES (TICK_CYCLES)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .start_addr (start_addr),
        .stop       (stop),
`ifdef AUDSEQ_LOOP_EN
        .loop       (loop),
`endif
        .period     (period),
        .mute       (mute),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [18:0] val;   // {period, mute, busy, done}
        int          len;   // 0 = length not checked
    } seg_t;

    seg_t        q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic        mon_en = 1'b0;
    logic        have = 1'b0;
    logic [18:0] prev = '0;
    int          run_len = 0;

    task automatic push(string tag, logic [15:0] p, logic m, logic b, logic d, int len);
        seg_t s;
        s.tag = tag;
        s.val = {p, m, b, d};
        s.len = len;
        q.push_back(s);
    endtask

    task automatic check_seg(logic [18:0] got, int len);
        seg_t e;
        n_vec++;
        if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_segment: got period=%h mute=%b busy=%b done=%b len=%0d, expected none",
                     got[18:3], got[2], got[1], got[0], len);
        end else begin
            e = q.pop_front();
            if (got != e.val || (e.len != 0 && e.len != len)) begin
                n_bad++;
                $display("FAIL %s: got period=%h mute=%b busy=%b done=%b len=%0d, expected period=%h mute=%b busy=%b done=%b len=%0d",
                         e.tag, got[18:3], got[2], got[1], got[0], len,
                         e.val[18:3], e.val[2], e.val[1], e.val[0], e.len);
            end
        end
    endtask

    task automatic chk(string tag, logic [18:0] exp);
        logic [18:0] got;
        got = {period, mute, busy, done};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got period=%h mute=%b busy=%b done=%b, expected period=%h mute=%b busy=%b done=%b",
                     tag, got[18:3], got[2], got[1], got[0], exp[18:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Monitor: closes a segment whenever the output tuple changes
    always @(negedge clk) begin
        if (mon_en) begin
            if (!have) begin
                prev    = {period, mute, busy, done};
                run_len = 1;
                have    = 1'b1;
            end else if ({period, mute, busy, done} == prev) begin
                run_len++;
            end else begin
                check_seg(prev, run_len);
                prev    = {period, mute, busy, done};
                run_len = 1;
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [ADDR_W-1:0] a, logic [15:0] p, logic [DUR_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = {p, d};
        tick(1);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_start(logic [ADDR_W-1:0] a);
        start_addr = a;
        start      = 1'b1;
        tick(1);
        start      = 1'b0;
    endtask

    task automatic flush_monitor();
        mon_en = 1'b0;
        if (have) check_seg(prev, run_len);
        have = 1'b0;
    endtask

    task automatic restart_monitor();
        have   = 1'b0;
        mon_en = 1'b1;
        push("idle", 16'h0000, 1'b1, 1'b0, 1'b0, 0);
    endtask

    // Expected segments of the standard 4-entry table played from address 0
    task automatic push_table(logic [15:0] first_p);
        push("start_latency", 16'h0000, 1'b1, 1'b1, 1'b0, 2);
        push("note0",         first_p,  1'b0, 1'b1, 1'b0, 10);
        push("rest1",         16'h0000, 1'b1, 1'b1, 1'b0, 6);
        push("note2",         16'h2000, 1'b0, 1'b1, 1'b0, 14);
        push("done_pulse",    16'h0000, 1'b1, 1'b0, 1'b1, 1);
        push("idle",          16'h0000, 1'b1, 1'b0, 1'b0, 0);
    endtask

    localparam logic [18:0] c_RESET_VAL = {16'h0000, 1'b1, 1'b0, 1'b0};

    initial begin
        // Reset behaviour
        tick(3);
        chk("reset_held", c_RESET_VAL);
        resetn = 1'b1;
        tick(1);
        chk("reset_released", c_RESET_VAL);
        restart_monitor();

        wr(0, 16'h1000, 2);
        wr(1, 16'h0000, 1);
        wr(2, 16'h2000, 3);
        wr(3, 16'h0000, 0);
        tick(2);

        // Full sequence
        push_table(16'h1000);
        pulse_start(0);
        tick(40);

        // Stop five cycles into the 0x2000 note, then a stop while idle
        push("start_latency", 16'h0000, 1'b1, 1'b1, 1'b0, 2);
        push("note0",         16'h1000, 1'b0, 1'b1, 1'b0, 10);
        push("rest1",         16'h0000, 1'b1, 1'b1, 1'b0, 6);
        push("note2_stopped", 16'h2000, 1'b0, 1'b1, 1'b0, 5);
        push("stop_done",     16'h0000, 1'b1, 1'b0, 1'b1, 1);
        push("idle",          16'h0000, 1'b1, 1'b0, 1'b0, 0);
        pulse_start(0);
        tick(22);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(5);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(5);

        // Address wrap from 63 to an end marker at 0
        wr(0, 16'h0000, 0);
        wr(63, 16'h0400, 1);
        push("start_latency", 16'h0000, 1'b1, 1'b1, 1'b0, 2);
        push("note63",        16'h0400, 1'b0, 1'b1, 1'b0, 6);
        push("wrap_done",     16'h0000, 1'b1, 1'b0, 1'b1, 1);
        push("idle",          16'h0000, 1'b1, 1'b0, 1'b0, 0);
        pulse_start(63);
        tick(15);
        wr(0, 16'h1000, 2);
        tick(2);

        // Start and stop in the same cycle while busy
        push("start_latency", 16'h0000, 1'b1, 1'b1, 1'b0, 2);
        push("note0_cut",     16'h1000, 1'b0, 1'b1, 1'b0, 3);
        push("startstop_done",16'h0000, 1'b1, 1'b0, 1'b1, 1);
        push("idle",          16'h0000, 1'b1, 1'b0, 1'b0, 0);
        pulse_start(0);
        tick(4);
        start = 1'b1;
        stop  = 1'b1;
        tick(1);
        start = 1'b0;
        stop  = 1'b0;
        tick(5);

        // Restart while playing entry 2: no done, replays from 0
        push("start_latency", 16'h0000, 1'b1, 1'b1, 1'b0, 2);
        push("note0",         16'h1000, 1'b0, 1'b1, 1'b0, 10);
        push("rest1",         16'h0000, 1'b1, 1'b1, 1'b0, 6);
        push("note2_restart", 16'h2000, 1'b0, 1'b1, 1'b0, 4);
        push("replay_note0",  16'h1000, 1'b0, 1'b1, 1'b0, 10);
        push("replay_rest1",  16'h0000, 1'b1, 1'b1, 1'b0, 6);
        push("replay_note2",  16'h2000, 1'b0, 1'b1, 1'b0, 14);
        push("replay_done",   16'h0000, 1'b1, 1'b0, 1'b1, 1);
        push("idle",          16'h0000, 1'b1, 1'b0, 1'b0, 0);
        pulse_start(0);
        tick(19);
        pulse_start(0);
        tick(40);

        // Write to the entry being fetched: old data plays, new data next time
        push_table(16'h1000);
        pulse_start(0);
        wr(0, 16'h3000, 2);
        tick(40);
        push_table(16'h3000);
        pulse_start(0);
        tick(40);
        wr(0, 16'h1000, 2);
        tick(2);

        // Asynchronous reset in the middle of a note
        flush_monitor();
        pulse_start(0);
        tick(5);
        chk("playing_before_reset", {16'h1000, 1'b0, 1'b1, 1'b0});
        #3;
        resetn = 1'b0;
        #1;
        chk("async_reset_mid_note", c_RESET_VAL);
        tick(3);
        resetn = 1'b1;
        tick(1);
        chk("after_async_reset", c_RESET_VAL);
        restart_monitor();
        tick(2);

`ifdef AUDSEQ_LOOP_EN
        // Loop pass, then loop dropped so the next end marker finishes
        loop = 1'b1;
        push("start_latency", 16'h0000, 1'b1, 1'b1, 1'b0, 2);
        push("note0",         16'h1000, 1'b0, 1'b1, 1'b0, 10);
        push("rest1",         16'h0000, 1'b1, 1'b1, 1'b0, 6);
        push("note2_loop",    16'h2000, 1'b0, 1'b1, 1'b0, 16);
        push("loop_note0",    16'h1000, 1'b0, 1'b1, 1'b0, 10);
        push("loop_rest1",    16'h0000, 1'b1, 1'b1, 1'b0, 6);
        push("loop_note2",    16'h2000, 1'b0, 1'b1, 1'b0, 14);
        push("loop_done",     16'h0000, 1'b1, 1'b0, 1'b1, 1);
        push("idle",          16'h0000, 1'b1, 1'b0, 1'b0, 0);
        pulse_start(0);
        tick(35);
        loop = 1'b0;
        tick(40);
`endif

        flush_monitor();
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d expected segments never observed, expected 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/audio_tone_sequencer.md
Name: audio_tone_sequencer

Overview:
- Upstream feeder for one channel of the 4-channel audio engine (audio_everything_4channel).
- Holds a small writable note table and, on a start pulse, plays a note sequence: drives a period word plus an explicit mute for a fixed duration per note.
- Implements the "tone sequence on demand" architecture. The top level (or the MIPS AHB bridge later) instantiates one per channel and wires `period` to periodN and `mute` into the mute vector.

Parameters:
- ADDR_W, 6, note table address width (depth = 2^ADDR_W entries).
- DUR_W, 8, note duration field width, in ticks.
- TICK_CYCLES, 25000, clk cycles per duration tick (1 ms at 25 MHz).

Ports:
- clk  in  1  system clock (clk25 domain).
- resetn  in  1  asynchronous active-low reset.
- wr_en  in  1  table write strobe.
- wr_addr  in  ADDR_W  table write address.
- wr_data  in  16+DUR_W  entry {period[15:0], dur[DUR_W-1:0]}.
- start  in  1  one-cycle pulse: begin playback at start_addr.
- start_addr  in  ADDR_W  first entry of the sequence.
- stop  in  1  one-cycle pulse: abort playback.
- period  out  16  current note period to the tone engine.
- mute  out  1  1 = channel silent.
- busy  out  1  1 while the sequencer is not in IDLE.
- done  out  1  one-cycle pulse when a sequence ends (end marker or stop).

Behaviour:
- Interface: one clock `clk`; reset `resetn` is asynchronous, active-low.
- Reset values: period=0, mute=1, busy=0, done=0, FSM=IDLE, address and tick counters = 0. Table contents are not reset.
- Table storage:
  - Synchronous RAM with 1-cycle read latency, read-first.
  - A read and a write to the same address in the same cycle return the old data.
  - Writes are accepted in every state.
- Entry decode:
  - dur==0 is the end marker; its period field is ignored.
  - period==0 with dur!=0 is a rest: mute=1, period=0.
  - Otherwise the note is audible: mute=0, period=entry period.
- FSM states: IDLE, FETCH, DECODE, PLAY.
  - IDLE: mute=1, period=0. On start, latch start_addr into addr and go to FETCH.
  - FETCH: present addr to the RAM, then go to DECODE.
  - DECODE, end marker: go to IDLE; done=1 next cycle; mute=1, period=0.
  - DECODE, note or rest: update period/mute on this edge, clear tick and duration counters, addr <= addr+1 (wraps modulo 2^ADDR_W), go to PLAY.
  - PLAY: the tick counter counts 0..TICK_CYCLES-1. On wrap, the duration counter increments. When the duration counter reaches dur, go to FETCH.
- Latency and timing:
  - From start sampled high in IDLE to period/mute valid is 3 clk edges.
  - Outputs hold through FETCH/DECODE of the next entry, so each note lasts exactly dur*TICK_CYCLES+2 cycles.
- busy is 1 in FETCH, DECODE and PLAY. done is asserted only for the single cycle after returning to IDLE.
- stop:
  - In any non-IDLE state: next edge goes to IDLE with mute=1, period=0 and done pulsed.
  - In IDLE: ignored (no done).
- start while busy restarts from the new start_addr (next state FETCH). No done is pulsed.
- start and stop in the same cycle: stop wins.
- A sequence with no end marker runs through the address wrap and continues from entry 0.
- Reset asserted mid-note forces all outputs to their reset values immediately (asynchronously).

Optional Feature:
- Macro: AUDSEQ_LOOP_EN.
- With the macro defined:
  - Adds input `loop` (1 bit) and an internal register holding the latched start_addr.
  - When DECODE hits an end marker while loop==1, addr reloads from the latched start_addr and the FSM goes to FETCH. done is not pulsed and mute stays at its previous note value during the 2-cycle refetch.
  - If loop==0 at the end marker, the sequence ends exactly as without the macro.
- Without the macro: no `loop` port; an end marker always ends the sequence.

Test Plan (TICK_CYCLES=4, DUR_W=8, ADDR_W=6):
- Reset: hold resetn=0, then release → period=0, mute=1, busy=0, done=0. Assert resetn=0 during PLAY → outputs return to reset values with no clock edge.
- Load {0x1000,2}, {0x0000,1}, {0x2000,3}, {0,0} at 0..3; start with start_addr=0:
  - 3 edges later period=0x1000, mute=0, held for 10 cycles.
  - Then period=0, mute=1 for 6 cycles.
  - Then 0x2000 for 14 cycles.
  - Then done pulses once, busy=0.
- Stop 5 cycles into note 0x2000 → next edge mute=1, period=0, done=1 for 1 cycle, IDLE. A stop pulse in IDLE → no done.
- Start with start_addr=63 where entry 63={0x0400,1} and entry 0 holds the end marker → plays 0x0400 for 6 cycles, addr wraps to 0, sequence ends with done.
- Same-cycle start+stop while busy → IDLE with done. Start alone while busy at addr 2 with start_addr=0 → replays 0x1000 with no done pulse. Write to the address being fetched → old data is played.
- AUDSEQ_LOOP_EN with loop=1 on the 4-entry table → 0x1000 reappears 2 cycles after the 0x2000 note ends, no done. Drop loop to 0 → the next end marker produces done.
